// File: rtl/hd63701_irq_arb_pkg.sv
// HD63701 interrupt arbiter shared defines: vector bytes, timer bit indices,
// arbiter FSM state encoding and the timer vector encoder.
package hd63701_irq_arb_pkg;

    localparam logic [7:0] VEC_NMI  = 8'hFC;
    localparam logic [7:0] VEC_IRQ1 = 8'hF8;
    localparam logic [7:0] VEC_ICF  = 8'hF6;
    localparam logic [7:0] VEC_OCF  = 8'hF4;
    localparam logic [7:0] VEC_TOF  = 8'hF2;
    localparam logic [7:0] VEC_SCI  = 8'hF0;

    localparam int unsigned TIM_ICF = 2;
    localparam int unsigned TIM_OCF = 1;
    localparam int unsigned TIM_TOF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_t;

    // Low nibble of the vector of the highest-priority eligible timer source.
    function automatic logic [3:0] tim_vec(input logic [2:0] elig);
        if (elig[TIM_ICF])      return VEC_ICF[3:0];
        else if (elig[TIM_OCF]) return VEC_OCF[3:0];
        else if (elig[TIM_TOF]) return VEC_TOF[3:0];
        else                    return 4'h0;
    endfunction

endpackage

// File: rtl/hd63701_irq_arb_if.sv
// HD63701 interrupt arbiter bus: pin/event/sequencer inputs and request outputs.
// slave = arbiter side, master = surrounding core / sequencer side.
interface hd63701_irq_arb_if;

    logic       NMI_PIN;
    logic       IRQ_PIN;
    logic       ICF_EV;
    logic       OCF_EV;
    logic       TOF_EV;
    logic [2:0] TIM_EN;
    logic [2:0] TIM_CLR;
    logic       SCI_IRQ;
    logic       INTA;
    logic [7:0] AVECT;
    logic       NMI;
    logic       IRQ;
    logic       IRQ2;
    logic       IRQ0;
    logic [3:0] IRQ2V;
    logic [2:0] TIM_PEND;

    modport master (
        output NMI_PIN, IRQ_PIN, ICF_EV, OCF_EV, TOF_EV, TIM_EN, TIM_CLR,
               SCI_IRQ, INTA, AVECT,
        input  NMI, IRQ, IRQ2, IRQ0, IRQ2V, TIM_PEND
    );

    modport slave (
        input  NMI_PIN, IRQ_PIN, ICF_EV, OCF_EV, TOF_EV, TIM_EN, TIM_CLR,
               SCI_IRQ, INTA, AVECT,
        output NMI, IRQ, IRQ2, IRQ0, IRQ2V, TIM_PEND
    );

endinterface

// File: rtl/hd63701_pin_sync.sv
// Conditioning for one active-low external pin: synchronizer, active level
// and a falling-edge pulse. HD63701_PIN_SYNC_EN selects a two-flop
// synchronizer; otherwise a single register stage is used.
module hd63701_pin_sync (
    input  logic CLK,
    input  logic RST,
    input  logic PIN,
    output logic LVL,
    output logic FALL
);

`ifdef HD63701_PIN_SYNC_EN
    localparam int unsigned STAGES = 2;
`else
    localparam int unsigned STAGES = 1;
`endif

    logic [STAGES-1:0] sync_q;
    logic [STAGES:0]   arm_q;
    logic              prev_q;
    logic              pin_s;

    assign pin_s = sync_q[STAGES-1];
    assign LVL   = ~pin_s;
    // arm_q masks the first real sample after reset, so a pin already low at
    // release is not mistaken for a falling edge against the reset value.
    assign FALL  = arm_q[STAGES] & prev_q & ~pin_s;

    // Shift the pin through the synchronizer and keep one sample of history.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            arm_q  <= '0;
        end else begin
`ifdef HD63701_PIN_SYNC_EN
            sync_q <= {sync_q[0], PIN};
`else
            sync_q <= PIN;
`endif
            prev_q <= pin_s;
            arm_q  <= {arm_q[STAGES-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/hd63701_irq_arb.sv
// HD63701 interrupt arbiter: NMI edge latch, IRQ1 level, timer pending
// latches (ICF/OCF/TOF), SCI level, fixed priority and vector-acknowledge FSM.
// Optional macro HD63701_PIN_SYNC_EN adds a second pin synchronizer stage.
module hd63701_irq_arb
    import hd63701_irq_arb_pkg::*;
(
    input logic               CLK,
    input logic               RST,
    hd63701_irq_arb_if.slave  bus
);

    arb_state_t state_q, state_d;
    logic       nmi_q;
    logic [2:0] pend_q;
    logic       irq_q, irq2_q, irq0_q;
    logic [3:0] irq2v_q;
    logic [2:0] tim_ev;
    logic [2:0] elig;
    logic       ack_nmi;
    logic [2:0] ack_tim;
    logic       any_req;
    logic       nmi_fall, nmi_lvl, irq_fall, irq_lvl;
    logic       unused_pins;

    hd63701_pin_sync u_nmi_sync (.CLK(CLK), .RST(RST), .PIN(bus.NMI_PIN), .LVL(nmi_lvl), .FALL(nmi_fall));
    hd63701_pin_sync u_irq_sync (.CLK(CLK), .RST(RST), .PIN(bus.IRQ_PIN), .LVL(irq_lvl), .FALL(irq_fall));

    assign unused_pins = nmi_lvl ^ irq_fall;
    assign elig        = pend_q & bus.TIM_EN;
    assign any_req     = nmi_q | irq_q | irq2_q | irq0_q;

    assign bus.NMI      = nmi_q;
    assign bus.IRQ      = irq_q;
    assign bus.IRQ2     = irq2_q;
    assign bus.IRQ0     = irq0_q;
    assign bus.IRQ2V    = irq2v_q;
    assign bus.TIM_PEND = pend_q;

    // Gather timer event pulses into TIM bit order.
    always_comb begin
        tim_ev          = '0;
        tim_ev[TIM_ICF] = bus.ICF_EV;
        tim_ev[TIM_OCF] = bus.OCF_EV;
        tim_ev[TIM_TOF] = bus.TOF_EV;
    end

    // Decode the acknowledged vector into latch clears.
    always_comb begin
        ack_nmi = 1'b0;
        ack_tim = '0;
        if (bus.INTA) begin
            case (bus.AVECT)
                VEC_NMI: ack_nmi          = 1'b1;
                VEC_ICF: ack_tim[TIM_ICF] = 1'b1;
                VEC_OCF: ack_tim[TIM_OCF] = 1'b1;
                VEC_TOF: ack_tim[TIM_TOF] = 1'b1;
                default: ;
            endcase
        end
    end

    // Source latches; a new event wins over any clear in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            nmi_q  <= 1'b0;
            pend_q <= '0;
        end else begin
            nmi_q  <= nmi_fall | (nmi_q & ~ack_nmi);
            pend_q <= tim_ev | (pend_q & ~bus.TIM_CLR & ~ack_tim);
        end
    end

    // Registered, priority-masked requests; timer vector frozen while in ACK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            irq_q   <= 1'b0;
            irq2_q  <= 1'b0;
            irq0_q  <= 1'b0;
            irq2v_q <= '0;
        end else begin
            irq_q  <= irq_lvl & ~nmi_q;
            irq2_q <= (|elig) & ~nmi_q & ~irq_lvl;
            irq0_q <= bus.SCI_IRQ & ~nmi_q & ~irq_lvl & ~(|elig);
            if (state_q != ST_ACK) begin
                irq2v_q <= tim_vec(elig);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (any_req) state_d = ST_REQ;
            ST_REQ: begin
                if (bus.INTA)      state_d = ST_ACK;
                else if (!any_req) state_d = ST_IDLE;
            end
            ST_ACK:  if (!bus.INTA) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_hd63701_irq_arb.sv
// Self-checking bench for hd63701_irq_arb: per-cycle expectations are pushed
// to a scoreboard queue as stimulus is driven and popped after each edge.
module tb_hd63701_irq_arb;

`ifdef HD63701_PIN_SYNC_EN
    localparam int L = 3;
`else
    localparam int L = 2;
`endif
    localparam logic [10:0] M_ALL = 11'h7FF;
    localparam logic [10:0] M_NMI = 11'h400;

    typedef struct {
        string       nm;
        logic [10:0] mask;
        logic [10:0] exp;
    } exp_t;

    logic CLK;
    logic RST;
    exp_t sb[$];
    int   total;
    int   bad;

    hd63701_irq_arb_if bus();

    hd63701_irq_arb dut (.CLK(CLK), .RST(RST), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Packs {NMI, IRQ, IRQ2, IRQ0, IRQ2V, TIM_PEND}.
    function automatic logic [10:0] pk(input logic n, input logic i, input logic i2,
                                       input logic i0, input logic [3:0] v, input logic [2:0] p);
        return {n, i, i2, i0, v, p};
    endfunction

    function automatic logic [10:0] outs();
        return {bus.NMI, bus.IRQ, bus.IRQ2, bus.IRQ0, bus.IRQ2V, bus.TIM_PEND};
    endfunction

    function automatic exp_t mk(input string nm, input logic [10:0] mask, input logic [10:0] exp);
        exp_t e;
        e.nm = nm; e.mask = mask; e.exp = exp;
        return e;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_idle();
        bus.NMI_PIN = 1'b1; bus.IRQ_PIN = 1'b1;
        bus.ICF_EV = 1'b0; bus.OCF_EV = 1'b0; bus.TOF_EV = 1'b0;
        bus.TIM_EN = 3'b000; bus.TIM_CLR = 3'b000;
        bus.SCI_IRQ = 1'b0; bus.INTA = 1'b0; bus.AVECT = 8'h00;
    endtask

    task automatic settle();
        drive_idle();
        bus.TIM_CLR = 3'b111;
        tick();
        bus.TIM_CLR = 3'b000;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        exp_t e; logic [10:0] o;
        RST = 1'b1;
        bus.IRQ_PIN = 1'b0; bus.OCF_EV = 1'b1; bus.SCI_IRQ = 1'b1; bus.TIM_EN = 3'b111;
        repeat (3) tick();
        sb.push_back(mk("reset_hold", M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000)));
        e = sb.pop_front(); o = outs(); total++;
        if ((o & e.mask) !== (e.exp & e.mask)) begin
            bad++; $display("FAIL %s: got %03h want %03h", e.nm, o & e.mask, e.exp & e.mask);
        end
        drive_idle();
        tick();
        RST = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_ocf();
        exp_t e; logic [10:0] o;
        bus.TIM_EN = 3'b010;
        for (int c = 0; c < 6; c++) begin
            bus.OCF_EV = (c == 0);
            bus.INTA   = (c == 3);
            bus.AVECT  = (c == 3) ? 8'hF4 : 8'h00;
            case (c)
                0: sb.push_back(mk("ocf_e1",  M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b010)));
                1: sb.push_back(mk("ocf_e2",  M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 3'b010)));
                2: sb.push_back(mk("ocf_req", M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 3'b010)));
                3: sb.push_back(mk("ocf_ack", M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 3'b000)));
                4: sb.push_back(mk("ocf_drop", M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 3'b000)));
                default: sb.push_back(mk("ocf_idle", M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000)));
            endcase
            tick();
            e = sb.pop_front(); o = outs(); total++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                bad++; $display("FAIL %s: got %03h want %03h", e.nm, o & e.mask, e.exp & e.mask);
            end
        end
        settle();
    endtask

    task automatic test_icf_tof();
        exp_t e; logic [10:0] o;
        bus.TIM_EN = 3'b111;
        for (int c = 0; c < 9; c++) begin
            bus.ICF_EV = (c == 0);
            bus.TOF_EV = (c == 0);
            bus.INTA   = (c == 3) || (c == 6);
            bus.AVECT  = (c == 3) ? 8'hF6 : (c == 6) ? 8'hF2 : 8'h00;
            case (c)
                0: sb.push_back(mk("it_e1",   M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b101)));
                1: sb.push_back(mk("it_e2",   M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 3'b101)));
                2: sb.push_back(mk("it_req",  M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 3'b101)));
                3: sb.push_back(mk("it_ackf6", M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 3'b001)));
                4: sb.push_back(mk("it_frz",  M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 3'b001)));
                5: sb.push_back(mk("it_tof",  M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 3'b001)));
                6: sb.push_back(mk("it_ackf2", M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 3'b000)));
                7: sb.push_back(mk("it_drop", M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 3'b000)));
                default: sb.push_back(mk("it_idle", M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000)));
            endcase
            tick();
            e = sb.pop_front(); o = outs(); total++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                bad++; $display("FAIL %s: got %03h want %03h", e.nm, o & e.mask, e.exp & e.mask);
            end
        end
        settle();
    endtask

    task automatic test_ack_freeze();
        exp_t e; logic [10:0] o;
        bus.TIM_EN = 3'b111;
        for (int c = 0; c < 10; c++) begin
            bus.TOF_EV = (c == 0);
            bus.OCF_EV = (c == 4);
            bus.INTA   = (c == 3) || (c == 7);
            bus.AVECT  = (c == 3) ? 8'hF2 : (c == 7) ? 8'hF4 : 8'h00;
            case (c)
                0: sb.push_back(mk("af_e1",   M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b001)));
                1: sb.push_back(mk("af_e2",   M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 3'b001)));
                2: sb.push_back(mk("af_req",  M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 3'b001)));
                3: sb.push_back(mk("af_ack",  M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 3'b000)));
                4: sb.push_back(mk("af_inack", M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 3'b010)));
                5: sb.push_back(mk("af_idle", M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 3'b010)));
                6: sb.push_back(mk("af_req2", M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 3'b010)));
                7: sb.push_back(mk("af_ack2", M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 3'b000)));
                8: sb.push_back(mk("af_drop", M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 3'b000)));
                default: sb.push_back(mk("af_end", M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000)));
            endcase
            tick();
            e = sb.pop_front(); o = outs(); total++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                bad++; $display("FAIL %s: got %03h want %03h", e.nm, o & e.mask, e.exp & e.mask);
            end
        end
        settle();
    endtask

    task automatic test_clr_vs_set();
        exp_t e; logic [10:0] o;
        logic [2:0] want [6] = '{3'b001, 3'b001, 3'b000, 3'b110, 3'b100, 3'b000};
        bus.TIM_EN = 3'b000;
        for (int c = 0; c < 6; c++) begin
            bus.TOF_EV  = (c == 0);
            bus.ICF_EV  = (c == 3);
            bus.OCF_EV  = (c == 3);
            bus.TIM_CLR = (c == 0) ? 3'b001 : (c == 2) ? 3'b001 :
                          (c == 4) ? 3'b010 : (c == 5) ? 3'b100 : 3'b000;
            sb.push_back(mk($sformatf("clrset_c%0d", c), M_ALL,
                            pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, want[c])));
            tick();
            e = sb.pop_front(); o = outs(); total++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                bad++; $display("FAIL %s: got %03h want %03h", e.nm, o & e.mask, e.exp & e.mask);
            end
        end
        settle();
    endtask

    task automatic test_en_drop();
        exp_t e; logic [10:0] o;
        bus.TIM_EN = 3'b001;
        for (int c = 0; c < 4; c++) begin
            bus.TOF_EV  = (c == 0);
            bus.TIM_EN  = (c >= 2) ? 3'b000 : 3'b001;
            bus.TIM_CLR = (c == 3) ? 3'b001 : 3'b000;
            case (c)
                0: sb.push_back(mk("en_e1",   M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b001)));
                1: sb.push_back(mk("en_e2",   M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 3'b001)));
                2: sb.push_back(mk("en_off",  M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b001)));
                default: sb.push_back(mk("en_clr", M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000)));
            endcase
            tick();
            e = sb.pop_front(); o = outs(); total++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                bad++; $display("FAIL %s: got %03h want %03h", e.nm, o & e.mask, e.exp & e.mask);
            end
        end
        settle();
    endtask

    task automatic test_irq_sci();
        exp_t e; logic [10:0] o;
        logic want_irq, want_irq0;
        for (int c = 0; c < 2 * L + 3; c++) begin
            if (c == 0)         bus.IRQ_PIN = 1'b0;
            if (c == L)         bus.SCI_IRQ = 1'b1;
            if (c == L + 1)     bus.IRQ_PIN = 1'b1;
            if (c == 2 * L + 1) bus.SCI_IRQ = 1'b0;
            want_irq  = (c + 1 >= L) && (c + 1 <= 2 * L);
            want_irq0 = (c + 1 == 2 * L + 1);
            sb.push_back(mk($sformatf("irqsci_c%0d", c), M_ALL,
                            pk(1'b0, want_irq, 1'b0, want_irq0, 4'h0, 3'b000)));
            tick();
            e = sb.pop_front(); o = outs(); total++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                bad++; $display("FAIL %s: got %03h want %03h", e.nm, o & e.mask, e.exp & e.mask);
            end
        end
        settle();
    endtask

    task automatic test_nmi();
        exp_t e; logic [10:0] o;
        int rises;
        logic prev;
        rises = 0;
        prev  = 1'b0;
        bus.NMI_PIN = 1'b0;
        for (int c = 0; c < 20; c++) begin
            sb.push_back(mk($sformatf("nmi_hold_c%0d", c), M_ALL,
                            pk((c + 1 >= L), 1'b0, 1'b0, 1'b0, 4'h0, 3'b000)));
            tick();
            e = sb.pop_front(); o = outs(); total++;
            if (o[10] && !prev) rises++;
            prev = o[10];
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                bad++; $display("FAIL %s: got %03h want %03h", e.nm, o & e.mask, e.exp & e.mask);
            end
        end
        total++;
        if (rises !== 1) begin
            bad++; $display("FAIL nmi_rise_count: got %0d want 1", rises);
        end
        for (int c = 0; c < 6; c++) begin
            bus.INTA  = (c == 0);
            bus.AVECT = (c == 0) ? 8'hFC : 8'h00;
            sb.push_back(mk($sformatf("nmi_acked_c%0d", c), M_ALL,
                            pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000)));
            tick();
            e = sb.pop_front(); o = outs(); total++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                bad++; $display("FAIL %s: got %03h want %03h", e.nm, o & e.mask, e.exp & e.mask);
            end
        end
        for (int c = 0; c < 3 + L + 2; c++) begin
            bus.NMI_PIN = (c < 3);
            sb.push_back(mk($sformatf("nmi_refall_c%0d", c), M_NMI,
                            pk((c + 1 >= 3 + L), 1'b0, 1'b0, 1'b0, 4'h0, 3'b000)));
            tick();
            e = sb.pop_front(); o = outs(); total++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                bad++; $display("FAIL %s: got %03h want %03h", e.nm, o & e.mask, e.exp & e.mask);
            end
        end
        bus.INTA = 1'b1; bus.AVECT = 8'hFC;
        tick();
        bus.INTA = 1'b0; bus.AVECT = 8'h00; bus.NMI_PIN = 1'b1;
        settle();
    endtask

    task automatic test_rst_mid_ack();
        exp_t e; logic [10:0] o;
        bus.TIM_EN = 3'b001;
        for (int c = 0; c < 4; c++) begin
            bus.TOF_EV = (c == 0);
            bus.INTA   = (c == 3);
            bus.AVECT  = (c == 3) ? 8'hF2 : 8'h00;
            case (c)
                0: sb.push_back(mk("ra_e1",  M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b001)));
                1: sb.push_back(mk("ra_e2",  M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 3'b001)));
                2: sb.push_back(mk("ra_req", M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 3'b001)));
                default: sb.push_back(mk("ra_ack", M_ALL, pk(1'b0, 1'b0, 1'b1, 1'b0, 4'h2, 3'b000)));
            endcase
            tick();
            e = sb.pop_front(); o = outs(); total++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                bad++; $display("FAIL %s: got %03h want %03h", e.nm, o & e.mask, e.exp & e.mask);
            end
        end
        bus.INTA = 1'b0; bus.AVECT = 8'h00; bus.NMI_PIN = 1'b0;
        RST = 1'b1;
        #1;
        sb.push_back(mk("ra_in_rst", M_ALL, pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000)));
        e = sb.pop_front(); o = outs(); total++;
        if ((o & e.mask) !== (e.exp & e.mask)) begin
            bad++; $display("FAIL %s: got %03h want %03h", e.nm, o & e.mask, e.exp & e.mask);
        end
        repeat (2) tick();
        RST = 1'b0;
        for (int c = 0; c < 8; c++) begin
            sb.push_back(mk($sformatf("ra_post_c%0d", c), M_ALL,
                            pk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'b000)));
            tick();
            e = sb.pop_front(); o = outs(); total++;
            if ((o & e.mask) !== (e.exp & e.mask)) begin
                bad++; $display("FAIL %s: got %03h want %03h", e.nm, o & e.mask, e.exp & e.mask);
            end
        end
        bus.NMI_PIN = 1'b1;
        settle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no summary by 100us want summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        RST   = 1'b1;
        drive_idle();
        test_reset();
        test_ocf();
        test_icf_tof();
        test_ack_freeze();
        test_clr_vs_set();
        test_en_drop();
        test_irq_sci();
        test_nmi();
        test_rst_mid_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hd63701_irq_arb.md
HD63701_IRQ_ARB -- requirements
Module: hd63701_irq_arb

Interface
REQ-001 SHALL have one clock and asynchronous active-high reset: ports CLK and RST.
REQ-002 CLK  input  1  core clock; all state changes on posedge CLK.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 NMI_PIN  input  1  external NMI pin, active-low, falling-edge triggered.
REQ-005 IRQ_PIN  input  1  external IRQ1 pin, active-low, level-sensitive.
REQ-006 ICF_EV / OCF_EV / TOF_EV  input  1 each  one-cycle timer event pulses.
REQ-007 TIM_EN  input  3  enables: [2] EICI, [1] EOCI, [0] ETOI.
REQ-008 TIM_CLR  input  3  software clear strobes; bit order as TIM_EN.
REQ-009 SCI_IRQ  input  1  SCI request, active-high level.
REQ-010 INTA  input  1  one-cycle pulse from the sequencer at vector load.
REQ-011 AVECT  input  8  vector byte being loaded; valid while INTA=1.
REQ-012 NMI / IRQ / IRQ2 / IRQ0  output  1 each  registered requests to the sequencer.
REQ-013 IRQ2V  output  4  low nibble of the timer vector byte.
REQ-014 TIM_PEND  output  3  pending timer latches, TIM_EN bit order.

Function
REQ-015 Event pulse SHALL set its pending latch on the next edge; TIM_CLR SHALL clear it; set wins over simultaneous clear.
REQ-016 NMI latch SHALL set on a synchronized NMI_PIN 1->0 transition; holding the pin low SHALL NOT retrigger.
REQ-017 Synchronized IRQ_PIN low SHALL drive IRQ high; no latch.
REQ-018 Priority: NMI > IRQ1 > ICF > OCF > TOF > SCI; a timer source is eligible only when its pending latch AND TIM_EN bit are set.
REQ-019 IRQ2V SHALL encode the highest eligible timer source: ICF 4'h6, OCF 4'h4, TOF 4'h2.
REQ-020 FSM states: IDLE, REQ, ACK.
REQ-021 IDLE->REQ when any output request is asserted.
REQ-022 REQ->ACK on INTA; IRQ2V, and the source that AVECT identifies, SHALL be frozen in ACK.
REQ-023 ACK->IDLE the cycle after INTA deasserts; if requests remain, go to REQ on the following edge.
REQ-024 REQ->IDLE, with no INTA, when all requests have dropped.
REQ-025 On INTA, AVECT decodes as: 8'hFC clears the NMI latch; 8'hF6/F4/F2 clear the ICF/OCF/TOF latch. Any other value clears nothing.
REQ-026 An event arriving in ACK SHALL latch, but SHALL NOT alter IRQ2V until IDLE.
REQ-027 Outputs SHALL change only on CLK edges; latency from event pulse to output is 2 cycles.
REQ-028 Clearing TIM_EN while pending SHALL drop IRQ2 next cycle but keep TIM_PEND.

Reset
REQ-029 RST SHALL clear all latches, synchronizers and the FSM (to IDLE).
REQ-030 During RST, NMI, IRQ, IRQ2 and IRQ0 SHALL be 0, IRQ2V SHALL be 4'h0 and TIM_PEND SHALL be 3'b000.
REQ-031 Synchronizer reset value SHALL be 1 (pins inactive), so release with NMI_PIN low produces no NMI.
REQ-032 RST mid-ACK SHALL discard the pending acknowledge.

Configuration
REQ-033 Macro HD63701_PIN_SYNC_EN defined: NMI_PIN and IRQ_PIN pass through two-flop synchronizers; event-to-output latency on pins is 3 cycles.
REQ-034 Macro HD63701_PIN_SYNC_EN undefined: a single register stage is used; pin latency is 2 cycles.

Structure
REQ-035 Vector bytes (FC, F8, F6, F4, F2, F0), TIM bit indices and FSM state encodings SHALL live in the shared HD63701 defines package.
REQ-036 One sub-module, hd63701_pin_sync (edge and level conditioning for one pin), SHALL be instantiated twice.

Verification
REQ-037 OCF_EV pulse with TIM_EN=3'b010 -> IRQ2=1, IRQ2V=4'h4 after 2 cycles; INTA with AVECT=8'hF4 -> TIM_PEND[1]=0, IRQ2=0.
REQ-038 ICF_EV and TOF_EV in the same cycle with TIM_EN=3'b111 -> IRQ2V=4'h6; after ack with 8'hF6 -> IRQ2V=4'h2.
REQ-039 NMI_PIN held low 20 cycles -> exactly one NMI assertion; after INTA with 8'hFC, NMI stays 0 until the pin returns high and falls again.
REQ-040 OCF_EV during ACK of TOF (8'hF2) -> IRQ2V stays 4'h2 through ACK, then 4'h4 after return to IDLE.
REQ-041 TIM_CLR[0] in the same cycle as TOF_EV -> TIM_PEND[0]=1.
REQ-042 RST asserted mid-ACK with NMI_PIN low at release -> all outputs 0 and no NMI.
